// File: rtl/tuner_select_if.sv
// Button inputs and tuner selection outputs of the tuner select controller.
interface tuner_select_if;
    logic       leftBtn;
    logic       rightBtn;
    logic       upBtn;
    logic       downBtn;
    logic [2:0] octaveState;
    logic [3:0] noteIdx;
    logic       changed;

    // Drives the buttons and observes the selection.
    modport master (
        output leftBtn, rightBtn, upBtn, downBtn,
        input  octaveState, noteIdx, changed
    );

    // The controller: consumes buttons and produces the selection.
    modport slave (
        input  leftBtn, rightBtn, upBtn, downBtn,
        output octaveState, noteIdx, changed
    );
endinterface

// File: rtl/tuner_select_ctrl.sv
// Tuner octave/note selector: four raw buttons are synchronized, debounced
// and auto-repeated; one event per cycle steps the octave (1..3) and note
// (0..11) with clamping, and changed pulses when the selection moves.
module tuner_select_ctrl #(
    parameter int unsigned DB_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic          clk,
    input  logic          rst_n,
    tuner_select_if.slave bus
);

    localparam int unsigned N_BTN   = 4;
    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam int unsigned OCT_W   = 3;
    localparam int unsigned NOTE_W  = 4;

    localparam logic [OCT_W-1:0]  OCT_MIN  = OCT_W'(1);
    localparam logic [OCT_W-1:0]  OCT_MAX  = OCT_W'(3);
    localparam logic [NOTE_W-1:0] NOTE_MAX = NOTE_W'(11);

    // Button slots, ordered by event priority (slot 0 wins).
    localparam logic [1:0] BTN_RIGHT = 2'd0;
    localparam logic [1:0] BTN_LEFT  = 2'd1;
    localparam logic [1:0] BTN_UP    = 2'd2;
    localparam logic [1:0] BTN_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    logic [N_BTN-1:0]  raw_c;
    logic [N_BTN-1:0]  sync1_q;
    logic [N_BTN-1:0]  sync2_q;
    logic [N_BTN-1:0]  db_q;
    logic [DB_W-1:0]   db_cnt_q  [N_BTN];
    rpt_state_e        st_q      [N_BTN];
    logic [RPT_W-1:0]  rpt_cnt_q [N_BTN];
    logic [N_BTN-1:0]  event_c;

    logic [OCT_W-1:0]  oct_q,  oct_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              changed_q, changed_d;

    assign raw_c = {bus.downBtn, bus.upBtn, bus.leftBtn, bus.rightBtn};

    // Two-flop synchronizer on every raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has differed for DB_CYCLES cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Press/repeat events decoded from each button's repeat state and hold counter.
    always_comb begin
        event_c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (st_q[i])
                ST_IDLE:   event_c[i] = db_q[i];
                ST_DELAY:  event_c[i] = db_q[i] && (rpt_cnt_q[i] == RPT_W'(REPEAT_DELAY - 1));
                ST_REPEAT: event_c[i] = db_q[i] && (rpt_cnt_q[i] == RPT_W'(REPEAT_RATE - 1));
                default:   event_c[i] = 1'b0;
            endcase
        end
    end

    // Per-button auto-repeat FSM; a debounced release returns to idle silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i]      <= ST_IDLE;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!db_q[i]) begin
                    st_q[i]      <= ST_IDLE;
                    rpt_cnt_q[i] <= '0;
                end else begin
                    case (st_q[i])
                        ST_IDLE: begin
                            st_q[i]      <= ST_DELAY;
                            rpt_cnt_q[i] <= '0;
                        end
                        ST_DELAY: begin
                            if (event_c[i]) begin
                                st_q[i]      <= ST_REPEAT;
                                rpt_cnt_q[i] <= '0;
                            end else begin
                                rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (event_c[i]) begin
                                rpt_cnt_q[i] <= '0;
                            end else begin
                                rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_W'(1);
                            end
                        end
                        default: begin
                            st_q[i]      <= ST_IDLE;
                            rpt_cnt_q[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Apply the highest-priority event with clamping; lower-priority events are dropped.
    always_comb begin
        oct_d  = oct_q;
        note_d = note_q;
        if (event_c[BTN_RIGHT]) begin
            if (oct_q < OCT_MAX) begin
                oct_d = oct_q + OCT_W'(1);
            end
        end else if (event_c[BTN_LEFT]) begin
            if (oct_q > OCT_MIN) begin
                oct_d = oct_q - OCT_W'(1);
            end
        end else if (event_c[BTN_UP]) begin
            if (note_q == NOTE_MAX) begin
                if (oct_q < OCT_MAX) begin
                    note_d = '0;
                    oct_d  = oct_q + OCT_W'(1);
                end
            end else begin
                note_d = note_q + NOTE_W'(1);
            end
        end else if (event_c[BTN_DOWN]) begin
            if (note_q == '0) begin
                if (oct_q > OCT_MIN) begin
                    note_d = NOTE_MAX;
                    oct_d  = oct_q - OCT_W'(1);
                end
            end else begin
                note_d = note_q - NOTE_W'(1);
            end
        end
        changed_d = (oct_d != oct_q) || (note_d != note_q);
    end

    // Selection and change-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oct_q     <= OCT_MIN;
            note_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            oct_q     <= oct_d;
            note_q    <= note_d;
            changed_q <= changed_d;
        end
    end

    assign bus.octaveState = oct_q;
    assign bus.noteIdx     = note_q;
    assign bus.changed     = changed_q;

endmodule
